character_scroll_feeder: RTL and testbench

//  Upstream feeder for the 3-digit 7-segment character shift chain. Holds a message of
//  5-bit character codes and, once started, presents one code at a time on A and pulses

---
 rtl/character_scroll_feeder_if.sv | 41 ++++
 rtl/character_scroll_feeder.sv | 219 +++++++++++++++++++++
 tb/tb_character_scroll_feeder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/character_scroll_feeder_if.sv
// ---------------------------------------------------------------------------
// character_scroll_feeder_if
//
// Bundles the message-buffer write port, the scroll control inputs and the
// downstream character/strobe outputs of character_scroll_feeder.
//
//   wr_en / wr_addr / wr_data : message buffer write port
//   len / loop                : message length (1..DEPTH) and wrap enable,
//                               sampled when a start is accepted
//   start / stop              : begin scroll (level) / abort scroll
//   A / S                     : character code and shift strobe to the chain
//   busy / done               : scrolling flag / end-of-message pulse
//
// master: the controlling side (drives writes and controls)
// slave : the feeder itself
// ---------------------------------------------------------------------------
interface character_scroll_feeder_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [4:0]    wr_data;
    logic [AW:0]   len;
    logic          loop;
    logic          start;
    logic          stop;
    logic [4:0]    A;
    logic          S;
    logic          busy;
    logic          done;

    modport master (
        output wr_en, wr_addr, wr_data, len, loop, start, stop,
        input  A, S, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, loop, start, stop,
        output A, S, busy, done
    );
endinterface

// File: rtl/character_scroll_feeder.sv
// ---------------------------------------------------------------------------
// character_scroll_feeder
//
// Feeds a message of 5-bit character codes into a 7-segment shift chain, one
// character per step. Each step is DIV clock cycles long:
//   PRESENT (1 cycle, new code on A) -> STROBE (1 cycle, S=1) ->
//   WAIT (DIV-2 cycles) -> next PRESENT
// so A changes one cycle before each S rising edge and S rises exactly every
// DIV cycles. After the last character either the pointer wraps to entry 0
// (loop) or FLUSH blank steps are emitted, a final WAIT period elapses and
// done pulses for one cycle.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : character_scroll_feeder_if.slave (write port, controls, A/S/busy/done)
//
// Parameters:
//   DEPTH : message buffer entries (power of 2)
//   AW    : log2(DEPTH)
//   DIV   : clock cycles between S rising edges (>= 3)
//   BLANK : code driven while idle / flushing
//   FLUSH : blank steps after the last character when not looping (>= 1)
// ---------------------------------------------------------------------------
module character_scroll_feeder #(
    parameter int         DEPTH = 16,
    parameter int         AW    = 4,
    parameter int         DIV   = 25000000,
    parameter logic [4:0] BLANK = 5'd31,
    parameter int         FLUSH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    character_scroll_feeder_if.slave   bus
);

    // WAIT lasts DIV-2 cycles, so the counter runs 0..DIV-3.
    localparam int CW  = (DIV - 2 > 1) ? $clog2(DIV - 2) : 1;
    localparam int FCW = (FLUSH + 1 > 2) ? $clog2(FLUSH + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_STROBE  = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW:0]     len_q, len_d;
    logic            loop_q, loop_d;
    logic            flush_q, flush_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic            done_d;

    logic [4:0]      a_q;
    logic            s_q;
    logic            busy_q;
    logic            done_q;

    // Character load controls for the A register.
    logic            load_mem;
    logic            load_blank;
    logic [AW-1:0]   rd_addr;

    logic            len_ok;
    logic            last_char;
    logic            wait_end;

    // ------------------------------------------------------------------
    // Message buffer: write any time, registered read straight into A.
    // Not cleared by reset.
    // ------------------------------------------------------------------
    logic [4:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // A is the buffer's output register. Reading and writing the same entry
    // on one edge returns the old contents because both are non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= BLANK;
        end else if (load_mem) begin
            a_q <= mem_q[rd_addr];
        end else if (load_blank) begin
            a_q <= BLANK;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign len_ok    = (bus.len != '0) && (bus.len <= (AW+1)'(DEPTH));
    assign last_char = ({1'b0, ptr_q} == (len_q - 1'b1));
    assign wait_end  = (cnt_q == CW'(DIV - 3));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            flush_q <= 1'b0;
            fcnt_q  <= '0;
            s_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            flush_q <= flush_d;
            fcnt_q  <= fcnt_d;
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            s_q     <= (state_d == ST_STROBE);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        loop_d     = loop_q;
        flush_d    = flush_q;
        fcnt_d     = fcnt_q;
        done_d     = 1'b0;
        load_mem   = 1'b0;
        load_blank = 1'b0;
        rd_addr    = ptr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && len_ok) begin
                    // len/loop are latched here; later changes are ignored.
                    len_d    = bus.len;
                    loop_d   = bus.loop;
                    ptr_d    = '0;
                    flush_d  = 1'b0;
                    fcnt_d   = '0;
                    rd_addr  = '0;
                    load_mem = 1'b1;
                    state_d  = ST_PRESENT;
                end
            end

            ST_PRESENT: begin
                state_d = ST_STROBE;
            end

            ST_STROBE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (!wait_end) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (flush_q) begin
                    if (fcnt_q == FCW'(FLUSH)) begin
                        // Final blank has had its full period; finish.
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fcnt_d     = fcnt_q + 1'b1;
                        load_blank = 1'b1;
                        state_d    = ST_PRESENT;
                    end
                end else if (last_char) begin
                    if (loop_q) begin
                        ptr_d    = '0;
                        rd_addr  = '0;
                        load_mem = 1'b1;
                    end else begin
                        flush_d    = 1'b1;
                        fcnt_d     = FCW'(1);
                        load_blank = 1'b1;
                    end
                    state_d = ST_PRESENT;
                end else begin
                    ptr_d    = ptr_q + 1'b1;
                    rd_addr  = ptr_q + 1'b1;
                    load_mem = 1'b1;
                    state_d  = ST_PRESENT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a start on the same edge.
        // A keeps whatever it currently shows.
        if (bus.stop) begin
            state_d    = ST_IDLE;
            done_d     = 1'b0;
            load_mem   = 1'b0;
            load_blank = 1'b0;
        end
    end

    assign bus.A    = a_q;
    assign bus.S    = s_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_character_scroll_feeder.sv
module tb_character_scroll_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 31;

    logic clk;
    logic rst;

    character_scroll_feeder_if #(.AW(AW)) bus ();

    character_scroll_feeder #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DIV   (DIV),
        .BLANK (5'd31),
        .FLUSH (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard of expected A codes, one per S rising edge.
    int sb[$];

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge.
    // ------------------------------------------------------------------
    int   pulse_cnt = 0;
    int   done_cnt  = 0;
    int   cyc       = 0;
    int   last_rise = -1;
    logic s_prev    = 1'b0;
    int   a_prev    = BLANK;
    int   a_rise    = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.S && !s_prev) begin
            pulse_cnt++;
            check("sb_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                int exp_a;
                exp_a = sb.pop_front();
                check("a_code", int'(bus.A), exp_a);
                $display("step %0d: A=%0d expected %0d", pulse_cnt, bus.A, exp_a);
            end
            check("a_setup", int'(bus.A), a_prev);
            if (last_rise >= 0) check("period", cyc - last_rise, DIV);
            last_rise = cyc;
            a_rise    = int'(bus.A);
        end
        if (s_prev) begin
            check("s_width", int'(bus.S), 0);
            if (bus.busy) check("a_hold", int'(bus.A), a_rise);
        end
        if (bus.done) begin
            done_cnt++;
            check("done_busy", int'(bus.busy), 0);
        end
        if (!bus.busy) last_rise = -1;
        s_prev = bus.S;
        a_prev = int'(bus.A);
    end

    // ------------------------------------------------------------------
    // Driver helpers (act 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = 5'(data);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_start(input int l, input int lp);
        bus.len   = (AW+1)'(l);
        bus.loop  = lp[0];
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_pulses(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && pulse_cnt < target; i++) tick();
        check(tag, int'(pulse_cnt >= target), 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.done) begin
                seen = 1;
                break;
            end
        end
        check(tag, seen, 1);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    task automatic push_msg(input int c0, input int c1, input int c2);
        sb.push_back(c0);
        sb.push_back(c1);
        sb.push_back(c2);
        for (int i = 0; i < 3; i++) sb.push_back(BLANK);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int base;
        int dbase;

        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.len     = '0;
        bus.loop    = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_A",    int'(bus.A), BLANK);
        check("rst_S",    int'(bus.S), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);

        write_mem(0, 1);
        write_mem(1, 2);
        write_mem(2, 3);

        // 1: non-looping scroll with flush
        base = pulse_cnt;
        push_msg(1, 2, 3);
        do_start(3, 0);
        check("t1_busy", int'(bus.busy), 1);
        check("t1_a0",   int'(bus.A), 1);
        wait_done("t1_done", 200);
        check("t1_pulses", pulse_cnt - base, 6);
        tick();
        check("t1_done_width", int'(bus.done), 0);
        check("t1_a_blank",    int'(bus.A), BLANK);

        // 3: invalid lengths ignored
        base = pulse_cnt;
        do_start(0, 0);
        check("t3_busy_len0", int'(bus.busy), 0);
        do_start(17, 0);
        check("t3_busy_len17", int'(bus.busy), 0);
        repeat (10) tick();
        check("t3_pulses", pulse_cnt - base, 0);
        check("t3_A",      int'(bus.A), BLANK);

        // 4a: start and len/loop changes mid-scroll ignored
        base = pulse_cnt;
        push_msg(1, 2, 3);
        do_start(3, 0);
        wait_pulses("t4_mid", base + 2, 40);
        bus.len   = (AW+1)'(1);
        bus.loop  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("t4_done", 200);
        check("t4_pulses", pulse_cnt - base, 6);

        // 4b: start+stop together in IDLE
        base = pulse_cnt;
        bus.len   = (AW+1)'(3);
        bus.loop  = 1'b0;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("t4b_busy", int'(bus.busy), 0);
        repeat (12) tick();
        check("t4b_pulses", pulse_cnt - base, 0);

        // 2: looping scroll, stopped after 8 pulses
        base  = pulse_cnt;
        dbase = done_cnt;
        for (int i = 0; i < 8; i++) sb.push_back((i % 3) + 1);
        do_start(3, 1);
        wait_pulses("t2_eight", base + 8, 100);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("t2_S",    int'(bus.S), 0);
        check("t2_busy", int'(bus.busy), 0);
        check("t2_A",    int'(bus.A), 2);
        repeat (12) tick();
        check("t2_pulses",  pulse_cnt - base, 8);
        check("t2_no_done", done_cnt - dbase, 0);
        check("t2_sb",      sb.size(), 0);

        // 5: reset while S is high, then restart from entry 0
        base = pulse_cnt;
        sb.push_back(1);
        do_start(3, 1);
        for (int i = 0; i < 20 && !bus.S; i++) tick();
        check("t5_s_seen", int'(bus.S), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_S",    int'(bus.S), 0);
        check("t5_A",    int'(bus.A), BLANK);
        check("t5_busy", int'(bus.busy), 0);
        sb.delete();
        push_msg(1, 2, 3);
        do_start(3, 0);
        check("t5_restart_a0", int'(bus.A), 1);
        wait_done("t5_done", 200);
        check("t5_pulses", pulse_cnt - base, 7);

        // 6: rewrite entry 2 while entry 1 is on display
        base = pulse_cnt;
        push_msg(1, 2, 9);
        do_start(3, 0);
        wait_pulses("t6_mid", base + 2, 40);
        write_mem(2, 9);
        wait_done("t6_done", 200);
        check("t6_pulses", pulse_cnt - base, 6);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
